// File: rtl/md_pkg.sv
// Shared definitions for the md issue controller: instruction IDs, latencies,
// state encoding and instruction-class decode.
package md_pkg;

    localparam int MD_ID_W    = 11;
    localparam int MD_CNT_W   = 4;
    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 10;

    typedef logic [MD_ID_W-1:0] md_id_t;

    localparam md_id_t NOP_ID   = 11'd0;
    localparam md_id_t ID_MFHI  = 11'd16;
    localparam md_id_t ID_MTHI  = 11'd17;
    localparam md_id_t ID_MFLO  = 11'd18;
    localparam md_id_t ID_MTLO  = 11'd19;
    localparam md_id_t ID_MULT  = 11'd24;
    localparam md_id_t ID_MULTU = 11'd25;
    localparam md_id_t ID_DIV   = 11'd26;
    localparam md_id_t ID_DIVU  = 11'd27;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } md_state_t;

    function automatic logic is_mul(input md_id_t id);
        return (id == ID_MULT) || (id == ID_MULTU);
    endfunction

    function automatic logic is_start(input md_id_t id);
        return is_mul(id) || (id == ID_DIV) || (id == ID_DIVU);
    endfunction

    function automatic logic is_mdcls(input md_id_t id);
        return is_start(id) || (id == ID_MFHI) || (id == ID_MFLO) ||
               (id == ID_MTHI) || (id == ID_MTLO);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_shadow_timer.sv
// Down-counting shadow of md occupancy: loaded on issue, counts to zero.
module md_shadow_timer
    import md_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    output logic [MD_CNT_W-1:0] cnt,
    output logic                busy
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: issue gating, D-stage stall,
// shadow occupancy tracking and md busy cross-check. MD_STALL_CNT_EN adds a stall counter.
//
// state   | meaning
// IDLE    | md free; a START in E may issue
// MUL_RUN | mult/multu in flight, shadow timer counting down
// DIV_RUN | div/divu in flight, shadow timer counting down
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT,
    parameter int ID_W    = MD_ID_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ID_W-1:0]     d_id,
    input  logic [ID_W-1:0]     e_id,
    input  logic                int_req,
    input  logic                md_busy,
    output logic [ID_W-1:0]     md_id,
    output logic                stall_d,
    output logic                shadow_busy,
    output logic [MD_CNT_W-1:0] shadow_cnt,
    output logic                err_mismatch,
    output logic [31:0]         stall_cycles
);

    md_state_t           state, state_nxt;
    logic                issue;
    logic                load;
    logic [MD_CNT_W-1:0] load_val;
    logic                timer_busy;
    logic                chk_en;

    assign issue = is_start(e_id) && !int_req && !shadow_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving RUN also when the timer is already empty keeps the FSM from sticking.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = is_mul(e_id) ? MUL_RUN : DIV_RUN;
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (!timer_busy || (shadow_cnt == MD_CNT_W'(1))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shadow_busy = (state != IDLE);
        load        = (state == IDLE) && issue;
        load_val    = is_mul(e_id) ? MD_CNT_W'(MUL_LAT) : MD_CNT_W'(DIV_LAT);
    end

    md_shadow_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .cnt      (shadow_cnt),
        .busy     (timer_busy)
    );

    assign stall_d = is_mdcls(d_id) && (shadow_busy || issue);
    assign md_id   = int_req ? NOP_ID : e_id;

    // The first cycle out of reset is skipped: md may still be settling.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_en       <= 1'b0;
            err_mismatch <= 1'b0;
        end else begin
            chk_en <= 1'b1;
            if (chk_en && (shadow_busy != md_busy)) begin
                err_mismatch <= 1'b1;
            end
        end
    end

`ifdef MD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_d && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
